// File: rtl/fpu_collect_pkg.sv
// rtl/fpu_collect_pkg.sv - shared status type, flag indices and flag merge helper for the FPU result collector
package fpu_collect_pkg;

    localparam int NV_BIT = 4;
    localparam int DZ_BIT = 3;
    localparam int OF_BIT = 2;
    localparam int UF_BIT = 1;
    localparam int NX_BIT = 0;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    function automatic status_t status_or(input status_t a, input status_t b);
        return status_t'(a | b);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count, full/empty and combinational head read
module sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Guard here as well so a careless caller cannot corrupt pointers.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wr_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fpu_result_collector.sv
// rtl/fpu_result_collector.sv - buffers FPU results with status, keeps sticky fflags and a saturating accept count
module fpu_result_collector
    import fpu_collect_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WIDTH-1:0]         fpu_result_i,
    input  logic [4:0]               fpu_status_i,
    input  logic                     fpu_valid_i,
    output logic                     fpu_ready_o,
    output logic [WIDTH-1:0]         res_data_o,
    output logic [4:0]               res_status_o,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    input  logic                     clr_flags_i,
    output logic [4:0]               fflags_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic [CNT_W-1:0]         accepted_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                    fifo_full, fifo_empty;
    logic                    push, pop;
    logic [WIDTH+4:0]        rd_entry;
    status_t                 push_status;
    status_t                 flags_q, flags_d;
    logic [CNT_W-1:0]        accepted_q, accepted_d;

    // Ready depends on registered occupancy only, never on res_ready_i.
    assign fpu_ready_o = ~fifo_full;
    assign res_valid_o = ~fifo_empty;
    assign push        = fpu_valid_i & fpu_ready_o;
    assign pop         = res_valid_o & res_ready_i;

    sync_fifo #(
        .WIDTH (WIDTH + 5),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_data_i ({fpu_status_i, fpu_result_i}),
        .push_i    (push),
        .pop_i     (pop),
        .rd_data_o (rd_entry),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (occupancy_o)
    );

    assign res_data_o   = rd_entry[WIDTH-1:0];
    assign res_status_o = rd_entry[WIDTH+4:WIDTH];

    // A clear that coincides with a push keeps the incoming flags.
    always_comb begin
        push_status = push ? status_t'(fpu_status_i) : '0;
        flags_d     = clr_flags_i ? push_status : status_or(flags_q, push_status);
        accepted_d  = (push && (accepted_q != CNT_MAX)) ? accepted_q + 1'b1 : accepted_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flags_q    <= '0;
            accepted_q <= '0;
        end else begin
            flags_q    <= flags_d;
            accepted_q <= accepted_d;
        end
    end

    assign fflags_o   = flags_q;
    assign accepted_o = accepted_q;

endmodule

// File: tb/tb_fpu_result_collector.sv
// tb/tb_fpu_result_collector.sv - directed self-checking bench for fpu_result_collector
module tb_fpu_result_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fpu_result;
    logic [4:0]  fpu_status;
    logic        fpu_valid;
    logic        res_ready;
    logic        clr_flags;

    logic        fpu_ready_a, res_valid_a;
    logic [31:0] res_data_a;
    logic [4:0]  res_status_a, fflags_a;
    logic [2:0]  occ_a;
    logic [15:0] acc_a;

    logic        fpu_ready_b, res_valid_b;
    logic [31:0] res_data_b;
    logic [4:0]  res_status_b, fflags_b;
    logic [2:0]  occ_b;
    logic [2:0]  acc_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpu_result_collector #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) u_dut_a (
        .clk_i        (clk),
        .rst_i        (rst),
        .fpu_result_i (fpu_result),
        .fpu_status_i (fpu_status),
        .fpu_valid_i  (fpu_valid),
        .fpu_ready_o  (fpu_ready_a),
        .res_data_o   (res_data_a),
        .res_status_o (res_status_a),
        .res_valid_o  (res_valid_a),
        .res_ready_i  (res_ready),
        .clr_flags_i  (clr_flags),
        .fflags_o     (fflags_a),
        .occupancy_o  (occ_a),
        .accepted_o   (acc_a)
    );

    fpu_result_collector #(.WIDTH(32), .DEPTH(4), .CNT_W(3)) u_dut_b (
        .clk_i        (clk),
        .rst_i        (rst),
        .fpu_result_i (fpu_result),
        .fpu_status_i (fpu_status),
        .fpu_valid_i  (fpu_valid),
        .fpu_ready_o  (fpu_ready_b),
        .res_data_o   (res_data_b),
        .res_status_o (res_status_b),
        .res_valid_o  (res_valid_b),
        .res_ready_i  (res_ready),
        .clr_flags_i  (clr_flags),
        .fflags_o     (fflags_b),
        .occupancy_o  (occ_b),
        .accepted_o   (acc_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        fpu_result = '0;
        fpu_status = '0;
        fpu_valid  = 1'b0;
        res_ready  = 1'b1;
        clr_flags  = 1'b0;
        cyc(2);
        rst = 1'b0;

        // 1: load one entry, then async reset mid-cycle
        res_ready  = 1'b0;
        fpu_valid  = 1'b1;
        fpu_result = 32'hAA;
        fpu_status = 5'b11111;
        cyc(1);
        fpu_valid = 1'b0;
        res_ready = 1'b1;
        check("pre_rst_occ", occ_a, 3'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_ready", fpu_ready_a, 1'b1);
        check("rst_valid", res_valid_a, 1'b0);
        check("rst_fflags", fflags_a, 5'd0);
        check("rst_occ", occ_a, 3'd0);
        check("rst_acc", acc_a, 16'd0);
        check("rst_data", res_data_a, 32'd0);
        cyc(1);
        rst = 1'b0;
        cyc(1);

        // 2: pass-through with one-cycle latency
        fpu_valid  = 1'b1;
        fpu_result = 32'h3F800000;
        fpu_status = 5'b00000;
        #1 check("no_bypass", res_valid_a, 1'b0);
        cyc(1);
        check("pt0_valid", res_valid_a, 1'b1);
        check("pt0_data", res_data_a, 32'h3F800000);
        check("pt0_status", res_status_a, 5'b00000);
        fpu_result = 32'h40490FDB;
        fpu_status = 5'b00001;
        cyc(1);
        check("pt1_data", res_data_a, 32'h40490FDB);
        check("pt1_status", res_status_a, 5'b00001);
        fpu_valid = 1'b0;
        cyc(1);
        check("pt_empty", res_valid_a, 1'b0);
        check("pt_fflags", fflags_a, 5'b00001);
        check("pt_acc", acc_a, 16'd2);

        // 3: fill with consumer stalled, then drain in order
        res_ready  = 1'b0;
        fpu_status = 5'b00000;
        fpu_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            fpu_result = i;
            cyc(1);
        end
        fpu_result = 32'd5;
        check("full_ready", fpu_ready_a, 1'b0);
        check("full_occ", occ_a, 3'd4);
        cyc(1);
        check("held_ready", fpu_ready_a, 1'b0);
        check("held_occ", occ_a, 3'd4);
        res_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("drain_%0d", k), res_data_a, 64'(k));
            if (k == 2) check("ready_rise", fpu_ready_a, 1'b1);
            if (k == 3) fpu_result = 32'd6;
            if (k == 4) fpu_valid = 1'b0;
            cyc(1);
        end
        check("drain_empty", res_valid_a, 1'b0);
        check("drain_acc", acc_a, 16'd8);

        // 4: steady push+pop at occupancy 2, pointers wrap
        res_ready = 1'b0;
        fpu_valid = 1'b1;
        fpu_result = 32'h100;
        cyc(1);
        fpu_result = 32'h101;
        cyc(1);
        res_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("pp_occ_%0d", k), occ_a, 3'd2);
            check($sformatf("pp_data_%0d", k), res_data_a, 64'(32'h100 + k));
            fpu_result = 32'h102 + k;
            cyc(1);
        end
        fpu_valid = 1'b0;
        check("pp_tail0", res_data_a, 32'h10A);
        cyc(1);
        check("pp_tail1", res_data_a, 32'h10B);
        cyc(1);
        check("pp_empty", occ_a, 3'd0);

        // 5: clear colliding with a push keeps the new flags
        clr_flags = 1'b1;
        cyc(1);
        clr_flags  = 1'b0;
        fpu_valid  = 1'b1;
        fpu_status = 5'b10000;
        cyc(1);
        check("nv_set", fflags_a, 5'b10000);
        clr_flags  = 1'b1;
        fpu_status = 5'b00100;
        cyc(1);
        check("clr_push", fflags_a, 5'b00100);
        fpu_valid = 1'b0;
        cyc(1);
        check("clr_only", fflags_a, 5'b00000);
        clr_flags  = 1'b0;
        fpu_status = 5'b00000;

        // 6: saturating counter, then reset with entries pending
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        check("sat_start", acc_b, 3'd0);
        fpu_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            fpu_result = k;
            cyc(1);
            check($sformatf("sat_%0d", k), acc_b, (k > 7) ? 3'd7 : 3'(k));
        end
        check("wide_acc", acc_a, 16'd10);
        fpu_valid = 1'b0;
        cyc(2);
        res_ready = 1'b0;
        fpu_valid = 1'b1;
        cyc(3);
        fpu_valid = 1'b0;
        check("pre_rst3_occ", occ_b, 3'd3);
        #2 rst = 1'b1;
        #1;
        check("rst3_occ", occ_b, 3'd0);
        check("rst3_valid", res_valid_b, 1'b0);
        check("rst3_acc", acc_b, 3'd0);
        cyc(1);
        rst = 1'b0;
        cyc(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
